// File: rtl/prml_pkg.sv
// Shared PRML trellis definitions: encoder phases, trellis state type, and the
// codeword / next-state table (also used by the decoder's error checks).
package prml_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SYM1,
    PH_SYM2,
    PH_TAIL1,
    PH_TAIL2
  } phase_t;

  typedef logic [1:0] trellis_t;

  // Returns {first, second} channel symbols for data bit d leaving state s.
  function automatic logic [1:0] codeword(trellis_t s, logic d);
    logic [1:0] cw;
    case (s)
      2'b00:   cw = d ? 2'b11 : 2'b00;
      2'b10:   cw = d ? 2'b00 : 2'b11;
      2'b11:   cw = d ? 2'b10 : 2'b01;
      default: cw = d ? 2'b01 : 2'b10;
    endcase
    return cw;
  endfunction

  // State holds {d[n-1], d[n-2]}: shift the new bit in, drop the oldest.
  function automatic trellis_t next_state(trellis_t s, logic d);
    return {d, s[1]};
  endfunction

endpackage

// File: rtl/prml_trellis_map.sv
// Combinational trellis lookup: codeword symbols and successor state for one bit.
module prml_trellis_map
  import prml_pkg::*;
(
  input  trellis_t   state,
  input  logic       data,
  output logic [1:0] sym_pair,
  output trellis_t   state_next
);

  assign sym_pair   = codeword(state, data);
  assign state_next = next_state(state, data);

endmodule

// File: rtl/prml_encoder.sv
// PRML channel encoder: one data bit in per codeword, two serial symbols out,
// optional zero tail after in_last to return the trellis to state 00.
module prml_encoder
  import prml_pkg::*;
#(
  parameter int unsigned TAIL_BITS = 2,
  parameter logic        IDLE_SYM  = 1'b0
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     in_data,
  input  logic     in_valid,
  input  logic     in_last,
  output logic     in_ready,
  output logic     out,
  output logic     out_valid,
  output logic     sym_first,
  output logic     frame_done,
  output trellis_t enc_state
);

  // Handshake: a bit transfers on a rising edge where in_valid && in_ready.
  // in_ready is registered and never depends on in_valid; upstream holds
  // in_data/in_last stable until the transfer happens.

  localparam logic [3:0] TAIL_LOAD = 4'(TAIL_BITS);

  phase_t     phase, phase_n;
  trellis_t   enc_n;
  logic       second_q, second_n;
  logic       last_q, last_n;
  logic [3:0] tail_cnt, tail_n;
  logic       out_n, out_valid_n, sym_first_n, frame_done_n, in_ready_n;

  logic       accept, tail_start, map_data;
  logic [1:0] sym_pair;
  trellis_t   state_next;

  prml_trellis_map u_map (
    .state      (enc_state),
    .data       (map_data),
    .sym_pair   (sym_pair),
    .state_next (state_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      phase      <= PH_IDLE;
      enc_state  <= 2'b00;
      second_q   <= 1'b0;
      last_q     <= 1'b0;
      tail_cnt   <= 4'd0;
      out        <= IDLE_SYM;
      out_valid  <= 1'b0;
      sym_first  <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      phase      <= phase_n;
      enc_state  <= enc_n;
      second_q   <= second_n;
      last_q     <= last_n;
      tail_cnt   <= tail_n;
      out        <= out_n;
      out_valid  <= out_valid_n;
      sym_first  <= sym_first_n;
      frame_done <= frame_done_n;
      in_ready   <= in_ready_n;
    end
  end

  always_comb begin
    phase_n      = phase;
    enc_n        = enc_state;
    second_n     = second_q;
    last_n       = last_q;
    tail_n       = tail_cnt;
    out_n        = IDLE_SYM;
    out_valid_n  = 1'b0;
    sym_first_n  = 1'b0;
    frame_done_n = 1'b0;

    accept     = in_valid && in_ready;
    // A tail codeword starts after the last data SYM2 or after a tail SYM2,
    // as long as tail bits remain.
    tail_start = ((phase == PH_SYM2 && last_q) || phase == PH_TAIL2) && (tail_cnt != 4'd0);
    map_data   = tail_start ? 1'b0 : in_data;

    unique case (phase)
      PH_SYM1: begin
        phase_n      = PH_SYM2;
        out_n        = second_q;
        out_valid_n  = 1'b1;
        frame_done_n = last_q && (tail_cnt == 4'd0);
      end
      PH_TAIL1: begin
        phase_n      = PH_TAIL2;
        out_n        = second_q;
        out_valid_n  = 1'b1;
        tail_n       = tail_cnt - 4'd1;
        frame_done_n = (tail_cnt == 4'd1);
      end
      default: begin
        if (tail_start) begin
          phase_n     = PH_TAIL1;
          out_n       = sym_pair[1];
          second_n    = sym_pair[0];
          enc_n       = state_next;
          out_valid_n = 1'b1;
          sym_first_n = 1'b1;
          last_n      = 1'b0;
        end else if (accept && phase != PH_TAIL2) begin
          phase_n     = PH_SYM1;
          out_n       = sym_pair[1];
          second_n    = sym_pair[0];
          enc_n       = state_next;
          out_valid_n = 1'b1;
          sym_first_n = 1'b1;
          last_n      = in_last;
          tail_n      = in_last ? TAIL_LOAD : 4'd0;
        end else begin
          phase_n = PH_IDLE;
          last_n  = 1'b0;
        end
      end
    endcase

    // Ready in the coming cycle unless a tail will follow the current codeword.
    in_ready_n = (phase_n == PH_IDLE) ||
                 (phase_n == PH_SYM2 && !(last_n && tail_n != 4'd0));
  end

endmodule
